// File: rtl/spi_txn_sequencer_pkg.sv
// spi_txn_sequencer_pkg: shared constants, state encoding and burst-length helper for the SPI transaction sequencer
package spi_txn_sequencer_pkg;
  localparam logic [7:0] WR_OPCODE = 8'h0A;
  localparam logic [7:0] RD_OPCODE = 8'h0B;
  localparam int LEN_W = 4;
  localparam int TMR_W = 11;
  localparam logic [LEN_W-1:0] MAX_LEN = 4'd8;
  localparam int CS_SETUP_CYC = 4;
  localparam int CS_HOLD_CYC = 4;
  localparam int GAP_CYC = 8;
  localparam int TIMEOUT_CYC = 1024;
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(CS_SETUP_CYC - 2);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(CS_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, SETUP, OPC, ADDR, DATA, HOLD, GAP} state_t;
  function automatic logic [LEN_W-1:0] eff_len(input logic rw, input logic [LEN_W-1:0] len);
    return (!rw || len == '0) ? LEN_W'(1) : (len > MAX_LEN) ? MAX_LEN : len;
  endfunction
endpackage

// File: rtl/spi_txn_sequencer_if.sv
// spi_txn_sequencer_if: command, byte-engine and read-stream signals; master = sequencer side, slave = host/engine side
interface spi_txn_sequencer_if;
  import spi_txn_sequencer_pkg::*;
  logic cmd_valid, cmd_ready, cmd_rw;
  logic [7:0] cmd_addr, cmd_wdata;
  logic [LEN_W-1:0] cmd_len;
  logic byte_ready, byte_start, byte_done;
  logic [7:0] byte_tx, byte_rx;
  logic cs_n, rd_valid, txn_done, txn_err;
  logic [7:0] rd_data;
  logic [LEN_W-1:0] rd_idx;
  modport master (
    input cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cmd_len, byte_ready, byte_done, byte_rx,
    output cmd_ready, byte_start, byte_tx, cs_n, rd_valid, rd_data, rd_idx, txn_done, txn_err
  );
  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cmd_len, byte_ready, byte_done, byte_rx,
    input cmd_ready, byte_start, byte_tx, cs_n, rd_valid, rd_data, rd_idx, txn_done, txn_err
  );
endinterface

// File: rtl/spi_txn_sequencer_cycle_timer.sv
// spi_cycle_timer: loadable down-counter saturating at zero (clk, rst active-low, load/val, en -> zero)
module spi_cycle_timer
  import spi_txn_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] val,
  input  logic             en,
  output logic             zero
);
  logic [TMR_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? val : (en && !zero) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: turns write/burst-read commands into cs_n-framed SPI byte sequences (clk, rst active-low, bus.master)
module spi_txn_sequencer
  import spi_txn_sequencer_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  spi_txn_sequencer_if.master bus
);
  state_t state_q, state_d;
  logic wait_q, wait_d, rw_q, rw_d, byte_start_q, byte_start_d, cs_n_q, cs_n_d;
  logic rd_valid_q, rd_valid_d, txn_done_q, txn_done_d, txn_err_q, txn_err_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, byte_tx_q, byte_tx_d, rd_data_q, rd_data_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, rd_idx_q, rd_idx_d;
  logic tmr_load, tmr_en, tmr_zero, last;
  logic [TMR_W-1:0] tmr_val;
  spi_cycle_timer u_timer (.clk(clk), .rst(rst), .load(tmr_load), .val(tmr_val), .en(tmr_en), .zero(tmr_zero));
  assign last = state_q == DATA && idx_q == len_q - 1'b1;
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    rw_d = rw_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    len_d = len_q;
    idx_d = idx_q;
    byte_tx_d = byte_tx_q;
    rd_data_d = rd_data_q;
    rd_idx_d = rd_idx_q;
    cs_n_d = cs_n_q;
    byte_start_d = 1'b0;
    rd_valid_d = 1'b0;
    txn_done_d = 1'b0;
    txn_err_d = 1'b0;
    tmr_load = 1'b0;
    tmr_val = GAP_LD;
    tmr_en = state_q != IDLE;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        rw_d = bus.cmd_rw;
        addr_d = bus.cmd_addr;
        wdata_d = bus.cmd_wdata;
        len_d = eff_len(bus.cmd_rw, bus.cmd_len);
        cs_n_d = 1'b0;
        tmr_load = 1'b1;
        tmr_val = SETUP_LD;
        state_d = SETUP;
      end
      SETUP: state_d = tmr_zero ? OPC : SETUP;
      OPC, ADDR, DATA: begin
        if (!wait_q) begin
          if (bus.byte_ready) begin
            byte_start_d = 1'b1;
            wait_d = 1'b1;
            tmr_load = 1'b1;
            tmr_val = TIMEOUT_LD;
            byte_tx_d = state_q == OPC ? (rw_q ? RD_OPCODE : WR_OPCODE) : state_q == ADDR ? addr_q : rw_q ? 8'h00 : wdata_q;
          end
        end else if (bus.byte_done) begin
          wait_d = 1'b0;
          state_d = state_q == OPC ? ADDR : state_q == ADDR ? DATA : last ? HOLD : DATA;
          idx_d = state_q == DATA ? idx_q + 1'b1 : '0;
          tmr_load = last;
          tmr_val = HOLD_LD;
          rd_valid_d = state_q == DATA && rw_q;
          rd_data_d = rd_valid_d ? bus.byte_rx : rd_data_q;
          rd_idx_d = rd_valid_d ? idx_q : rd_idx_q;
        end else if (tmr_zero) begin
          wait_d = 1'b0;
          cs_n_d = 1'b1;
          txn_done_d = 1'b1;
          txn_err_d = 1'b1;
          tmr_load = 1'b1;
          state_d = GAP;
        end
      end
      HOLD: if (tmr_zero) begin
        cs_n_d = 1'b1;
        txn_done_d = 1'b1;
        tmr_load = 1'b1;
        state_d = GAP;
      end
      GAP: state_d = tmr_zero ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q <= 1'b0;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      byte_tx_q <= '0;
      rd_data_q <= '0;
      rd_idx_q <= '0;
      cs_n_q <= 1'b1;
      byte_start_q <= 1'b0;
      rd_valid_q <= 1'b0;
      txn_done_q <= 1'b0;
      txn_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      len_q <= len_d;
      idx_q <= idx_d;
      byte_tx_q <= byte_tx_d;
      rd_data_q <= rd_data_d;
      rd_idx_q <= rd_idx_d;
      cs_n_q <= cs_n_d;
      byte_start_q <= byte_start_d;
      rd_valid_q <= rd_valid_d;
      txn_done_q <= txn_done_d;
      txn_err_q <= txn_err_d;
    end
  end
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.byte_start = byte_start_q;
  assign bus.byte_tx = byte_tx_q;
  assign bus.cs_n = cs_n_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_idx = rd_idx_q;
  assign bus.txn_done = txn_done_q;
  assign bus.txn_err = txn_err_q;
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb_spi_txn_sequencer: directed plus randomized frames checked against a frame-level reference model
module tb_spi_txn_sequencer;
  localparam int CS_SETUP_CYC = 4;
  localparam int CS_HOLD_CYC = 4;
  localparam int GAP_CYC = 8;
  localparam int TIMEOUT_CYC = 1024;
  localparam int MAX_LEN = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  spi_txn_sequencer_if bus();
  spi_txn_sequencer dut (.clk(clk), .rst(rst), .bus(bus.master));
  int vectors = 0, miscompares = 0, cyc = 0;
  int n_done, n_err, bad_start, cs_glitch, tx_unstable, first_start;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, start_cyc = 0, last_done_cyc = 0, err_cyc = 0, prev_rise;
  logic [7:0] tx[$];
  logic [7:0] rd_d[$];
  logic [3:0] rd_i[$];
  logic [7:0] rx_pat[16];
  int eng_cnt = -1, eng_k = 0, lat = 2, rdy_delay = 0, rdy_wait = 0, hang_k = -1;
  bit keep_valid = 0, pat11 = 0;
  logic prev_cs = 1'b1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_mon();
    n_done = 0;
    n_err = 0;
    bad_start = 0;
    cs_glitch = 0;
    tx_unstable = 0;
    first_start = -1;
    tx.delete();
    rd_d.delete();
    rd_i.delete();
    eng_k = 0;
    for (int k = 0; k < 16; k++) rx_pat[k] = (pat11 && k >= 2) ? 8'((k - 1) * 17) : 8'($urandom);
  endtask
  task automatic tick();
    bit acc;
    acc = bus.cmd_valid && bus.cmd_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc && !keep_valid) bus.cmd_valid = 1'b0;
    if (prev_cs && !bus.cs_n) cs_fall_cyc = cyc;
    if (!prev_cs && bus.cs_n) begin
      cs_rise_cyc = cyc;
      if (rst && !bus.txn_done) cs_glitch++;
    end
    prev_cs = bus.cs_n;
    if (bus.txn_done) n_done++;
    if (bus.txn_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (bus.rd_valid) begin
      rd_d.push_back(bus.rd_data);
      rd_i.push_back(bus.rd_idx);
    end
    if (bus.byte_start && (!bus.byte_ready || bus.cs_n)) bad_start++;
    bus.byte_done = 1'b0;
    if (eng_cnt == 0) begin
      if (tx.size() > 0 && bus.byte_tx !== tx[$]) tx_unstable++;
      bus.byte_done = 1'b1;
      bus.byte_rx = eng_k < 16 ? rx_pat[eng_k] : 8'h00;
      eng_k++;
      last_done_cyc = cyc;
      eng_cnt = -1;
      rdy_wait = rdy_delay;
    end else if (eng_cnt > 0) eng_cnt--;
    else if (eng_cnt == -1 && !bus.byte_ready) begin
      if (rdy_wait > 0) rdy_wait--;
      else bus.byte_ready = 1'b1;
    end
    if (bus.byte_start) begin
      tx.push_back(bus.byte_tx);
      start_cyc = cyc;
      if (first_start < 0) first_start = cyc;
      bus.byte_ready = 1'b0;
      eng_cnt = (eng_k == hang_k) ? -2 : lat;
    end
  endtask
  task automatic wait_done();
    for (int i = 0; i < 4000 && n_done == 0; i++) tick();
    chk("frame_done", n_done, 1);
  endtask
  task automatic check_frame(input logic rw, input logic [7:0] a, input logic [7:0] w, input logic [3:0] l);
    int eff;
    eff = !rw ? 1 : l == 0 ? 1 : int'(l) > MAX_LEN ? MAX_LEN : int'(l);
    chk("tx_count", tx.size(), 2 + eff);
    for (int i = 0; i < tx.size() && i < 2 + eff; i++)
      chk($sformatf("tx_byte%0d", i), tx[i], i == 0 ? (rw ? 8'h0B : 8'h0A) : i == 1 ? a : rw ? 8'h00 : w);
    chk("rd_count", rd_d.size(), rw ? eff : 0);
    for (int i = 0; i < rd_d.size() && i < 14; i++) begin
      chk($sformatf("rd_data%0d", i), rd_d[i], rx_pat[2 + i]);
      chk($sformatf("rd_idx%0d", i), rd_i[i], i);
    end
    chk("txn_err", n_err, 0);
    chk("start_rules", bad_start, 0);
    chk("cs_held_low", cs_glitch, 0);
    chk("tx_stable", tx_unstable, 0);
    chk("cs_setup", first_start - cs_fall_cyc >= CS_SETUP_CYC, 1);
    chk("cs_hold", cs_rise_cyc - last_done_cyc > CS_HOLD_CYC, 1);
  endtask
  task automatic drive_cmd(input logic rw, input logic [7:0] a, input logic [7:0] w, input logic [3:0] l);
    bus.cmd_rw = rw;
    bus.cmd_addr = a;
    bus.cmd_wdata = w;
    bus.cmd_len = l;
    bus.cmd_valid = 1'b1;
  endtask
  task automatic run_txn(input logic rw, input logic [7:0] a, input logic [7:0] w, input logic [3:0] l);
    clear_mon();
    drive_cmd(rw, a, w, l);
    wait_done();
    check_frame(rw, a, w, l);
  endtask
  initial begin
    logic rw;
    logic [7:0] a, w;
    logic [3:0] l;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.cmd_len = '0;
    bus.byte_ready = 1'b1;
    bus.byte_done = 1'b0;
    bus.byte_rx = '0;
    clear_mon();
    repeat (3) tick();
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_byte_start", bus.byte_start, 0);
    chk("rst_byte_tx", bus.byte_tx, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_idx", bus.rd_idx, 0);
    chk("rst_txn_done", bus.txn_done, 0);
    chk("rst_txn_err", bus.txn_err, 0);
    rst = 1'b1;
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    run_txn(1'b0, 8'h2D, 8'h02, 4'd0);
    pat11 = 1;
    run_txn(1'b1, 8'h0E, 8'h00, 4'd6);
    pat11 = 0;
    run_txn(1'b1, 8'h21, 8'h00, 4'd0);
    run_txn(1'b1, 8'h22, 8'h00, 4'd15);
    for (int n = 0; n < 10; n++) begin
      rw = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      w = 8'($urandom);
      l = 4'($urandom_range(0, 15));
      lat = $urandom_range(1, 4);
      rdy_delay = $urandom_range(0, 3);
      run_txn(rw, a, w, l);
    end
    lat = 2;
    rdy_delay = 0;
    clear_mon();
    hang_k = 1;
    drive_cmd(1'b1, 8'h08, 8'h00, 4'd2);
    wait_done();
    chk("to_err", n_err, 1);
    chk("to_latency", err_cyc - start_cyc >= TIMEOUT_CYC - 2 && err_cyc - start_cyc <= TIMEOUT_CYC + 2, 1);
    chk("to_cs_n", bus.cs_n, 1);
    chk("to_tx_count", tx.size(), 2);
    hang_k = -1;
    eng_cnt = 3;
    repeat (6) tick();
    chk("late_done_no_txn", n_done, 1);
    chk("late_done_no_rd", rd_d.size(), 0);
    chk("late_done_cs_n", bus.cs_n, 1);
    chk("gap_busy", bus.cmd_ready, 0);
    run_txn(1'b0, 8'h1A, 8'h5C, 4'd3);
    clear_mon();
    drive_cmd(1'b1, 8'h30, 8'h00, 4'd6);
    for (int i = 0; i < 500 && rd_d.size() < 2; i++) tick();
    chk("mid_rst_reach", rd_d.size(), 2);
    rst = 1'b0;
    tick();
    chk("mid_rst_cs_n", bus.cs_n, 1);
    chk("mid_rst_byte_start", bus.byte_start, 0);
    chk("mid_rst_rd_valid", bus.rd_valid, 0);
    eng_cnt = -1;
    bus.byte_ready = 1'b1;
    bus.byte_done = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    chk("mid_rst_cs_idle", bus.cs_n, 1);
    clear_mon();
    keep_valid = 1;
    drive_cmd(1'b0, 8'h1F, 8'hA5, 4'd0);
    wait_done();
    check_frame(1'b0, 8'h1F, 8'hA5, 4'd0);
    prev_rise = cs_rise_cyc;
    keep_valid = 0;
    clear_mon();
    bus.byte_ready = 1'b0;
    rdy_wait = 30;
    wait_done();
    check_frame(1'b0, 8'h1F, 8'hA5, 4'd0);
    chk("gap_cycles", cs_fall_cyc - prev_rise >= GAP_CYC, 1);
    chk("ready_delays_start", first_start - cs_fall_cyc >= 20, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
